// File: rtl/nmi_bus_guard.sv
// Registered NMI bus stage with a per-transaction watchdog: a hung target is
// answered with ERR_RDATA so the core never stalls, and each timeout is logged.
module nmi_bus_guard #(
  parameter int          TIMEOUT   = 1024,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // upstream (core side)
  input  logic        slv_valid_i,
  input  logic [31:0] slv_addr_i,
  input  logic [31:0] slv_wdata_i,
  input  logic [3:0]  slv_wstrb_i,
  output logic [31:0] slv_rdata_o,
  output logic        slv_ready_o,
  // downstream (interconnect side)
  output logic        mst_valid_o,
  output logic [31:0] mst_addr_o,
  output logic [31:0] mst_wdata_o,
  output logic [3:0]  mst_wstrb_o,
  input  logic [31:0] mst_rdata_i,
  input  logic        mst_ready_i,
  // status
  input  logic        err_clr_i,
  output logic        err_o,
  output logic [31:0] err_addr_o,
  output logic        err_we_o,
  output logic [7:0]  err_cnt_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   err_addr_q, err_addr_d;
  logic          err_we_q, err_we_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          irq_q, irq_d;
  logic          timeout_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_we_q   <= 1'b0;
      err_cnt_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      err_we_q   <= err_we_d;
      err_cnt_q  <= err_cnt_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_addr_d  = err_addr_q;
    err_we_d    = err_we_q;
    err_cnt_d   = err_cnt_q;
    irq_d       = 1'b0;
    timeout_hit = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (slv_valid_i) begin
          addr_d  = slv_addr_i;
          wdata_d = slv_wdata_i;
          wstrb_d = slv_wstrb_i;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mst_ready_i) begin
          rdata_d = mst_rdata_i;
          state_d = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          timeout_hit = 1'b1;
          rdata_d     = ERR_RDATA;
          err_addr_d  = addr_q;
          err_we_d    = |wstrb_q;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          irq_d       = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // a timeout in the same cycle as a clear request leaves the flag set
    if (timeout_hit)    err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
    else                err_d = err_q;
  end

  assign mst_valid_o = (state_q == REQ);
  assign mst_addr_o  = addr_q;
  assign mst_wdata_o = wdata_q;
  assign mst_wstrb_o = wstrb_q;
  assign slv_ready_o = (state_q == RESP);
  assign slv_rdata_o = rdata_q;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;
  assign err_we_o    = err_we_q;
  assign err_cnt_o   = err_cnt_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_nmi_bus_guard.sv
// Directed bench for nmi_bus_guard with TIMEOUT = 16; cycle 0 is the cycle in
// which the core raises slv_valid.
module tb_nmi_bus_guard;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        slv_valid_i;
  logic [31:0] slv_addr_i, slv_wdata_i;
  logic [3:0]  slv_wstrb_i;
  logic [31:0] slv_rdata_o;
  logic        slv_ready_o;
  logic        mst_valid_o;
  logic [31:0] mst_addr_o, mst_wdata_o;
  logic [3:0]  mst_wstrb_o;
  logic [31:0] mst_rdata_i;
  logic        mst_ready_i;
  logic        err_clr_i;
  logic        err_o;
  logic [31:0] err_addr_o;
  logic        err_we_o;
  logic [7:0]  err_cnt_o;
  logic        irq_o;

  int n_checks = 0;
  int n_errors = 0;

  nmi_bus_guard #(.TIMEOUT(16), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .slv_valid_i(slv_valid_i), .slv_addr_i(slv_addr_i), .slv_wdata_i(slv_wdata_i),
    .slv_wstrb_i(slv_wstrb_i), .slv_rdata_o(slv_rdata_o), .slv_ready_o(slv_ready_o),
    .mst_valid_o(mst_valid_o), .mst_addr_o(mst_addr_o), .mst_wdata_o(mst_wdata_o),
    .mst_wstrb_o(mst_wstrb_o), .mst_rdata_i(mst_rdata_i), .mst_ready_i(mst_ready_i),
    .err_clr_i(err_clr_i), .err_o(err_o), .err_addr_o(err_addr_o),
    .err_we_o(err_we_o), .err_cnt_o(err_cnt_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // rdy_cyc / clr_cyc = 0 means never.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input int rdy_cyc, input logic [31:0] trd, input int clr_cyc,
                         output int resp_cyc, output logic [31:0] rd, output int irq_cyc,
                         output int irq_n, output int hs_n, output int unstable);
    resp_cyc = -1; rd = '0; irq_cyc = -1; irq_n = 0; hs_n = 0; unstable = 0;
    step();
    slv_valid_i = 1'b1; slv_addr_i = a; slv_wdata_i = wd; slv_wstrb_i = ws;
    for (int c = 1; c <= 40 && resp_cyc < 0; c++) begin
      step();
      if (irq_o) begin irq_n++; irq_cyc = c; end
      if (slv_ready_o) begin
        resp_cyc = c; rd = slv_rdata_o;
        slv_valid_i = 1'b0; mst_ready_i = 1'b0; err_clr_i = 1'b0;
      end else begin
        if (mst_valid_o && (mst_addr_o !== a || mst_wdata_o !== wd || mst_wstrb_o !== ws))
          unstable++;
        mst_ready_i = (c == rdy_cyc);
        mst_rdata_i = (c == rdy_cyc) ? trd : 32'h0;
        err_clr_i   = (c == clr_cyc);
        if (mst_valid_o && mst_ready_i) hs_n++;
      end
    end
    if (resp_cyc < 0) begin
      chk("resp_within_budget", 32'd0, 32'd1);
      slv_valid_i = 1'b0; mst_ready_i = 1'b0; err_clr_i = 1'b0;
    end
  endtask

  int          rc, ic, in_, hs, us, stray;
  logic [31:0] rd;

  initial begin
    rst_i = 1'b1; slv_valid_i = 1'b0; slv_addr_i = '0; slv_wdata_i = '0; slv_wstrb_i = '0;
    mst_rdata_i = '0; mst_ready_i = 1'b0; err_clr_i = 1'b0;
    repeat (3) step();
    chk("rst_mst_valid", 32'(mst_valid_o), 32'd0);
    chk("rst_slv_ready", 32'(slv_ready_o), 32'd0);
    chk("rst_irq",       32'(irq_o), 32'd0);
    chk("rst_err",       32'(err_o), 32'd0);
    chk("rst_err_addr",  err_addr_o, 32'd0);
    chk("rst_err_cnt",   32'(err_cnt_o), 32'd0);
    chk("rst_rdata",     slv_rdata_o, 32'd0);
    chk("rst_mst_addr",  mst_addr_o, 32'd0);
    rst_i = 1'b0;

    // zero-wait read
    run_txn(32'h0300_0000, 32'h0, 4'h0, 1, 32'h1234_5678, 0, rc, rd, ic, in_, hs, us);
    chk("zw_resp_cycle", 32'(rc), 32'd2);
    chk("zw_rdata",      rd, 32'h1234_5678);
    chk("zw_err",        32'(err_o), 32'd0);
    chk("zw_irq_n",      32'(in_), 32'd0);

    // write, target ready after 5 wait cycles (ready in REQ cycle 6)
    run_txn(32'h0400_0010, 32'hA5A5_A5A5, 4'b0011, 6, 32'h0000_0077, 0, rc, rd, ic, in_, hs, us);
    chk("wr_resp_cycle", 32'(rc), 32'd7);
    chk("wr_unstable",   32'(us), 32'd0);
    chk("wr_handshakes", 32'(hs), 32'd1);
    chk("wr_rdata",      rd, 32'h0000_0077);

    // timeout on read
    run_txn(32'h1000_0040, 32'h0, 4'h0, 0, 32'h0, 0, rc, rd, ic, in_, hs, us);
    chk("to_resp_cycle", 32'(rc), 32'd17);
    chk("to_irq_cycle",  32'(ic), 32'd17);
    chk("to_rdata",      rd, 32'hDEAD_BEEF);
    chk("to_err",        32'(err_o), 32'd1);
    chk("to_err_addr",   err_addr_o, 32'h1000_0040);
    chk("to_err_we",     32'(err_we_o), 32'd0);
    chk("to_err_cnt",    32'(err_cnt_o), 32'd1);
    chk("to_handshakes", 32'(hs), 32'd0);
    step();
    chk("to_irq_pulse_end", 32'(irq_o), 32'd0);

    // ready in the last REQ cycle is a normal completion
    run_txn(32'h2000_0000, 32'h0, 4'h0, 16, 32'hCAFE_0016, 0, rc, rd, ic, in_, hs, us);
    chk("edge_resp_cycle", 32'(rc), 32'd17);
    chk("edge_rdata",      rd, 32'hCAFE_0016);
    chk("edge_irq_n",      32'(in_), 32'd0);
    chk("edge_err_cnt",    32'(err_cnt_o), 32'd1);

    // write timeout, then a late ready while idle
    run_txn(32'h3000_0008, 32'h1111_2222, 4'b1000, 0, 32'h0, 0, rc, rd, ic, in_, hs, us);
    chk("wto_err_we",   32'(err_we_o), 32'd1);
    chk("wto_err_addr", err_addr_o, 32'h3000_0008);
    chk("wto_err_cnt",  32'(err_cnt_o), 32'd2);
    step();
    mst_ready_i = 1'b1; mst_rdata_i = 32'hFFFF_0000;
    step();
    chk("late_mst_valid", 32'(mst_valid_o), 32'd0);
    chk("late_slv_ready", 32'(slv_ready_o), 32'd0);
    step();
    chk("late_slv_ready2", 32'(slv_ready_o), 32'd0);
    chk("late_rdata_held", slv_rdata_o, 32'hDEAD_BEEF);
    mst_ready_i = 1'b0;
    run_txn(32'h0500_0000, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 0, rc, rd, ic, in_, hs, us);
    chk("after_late_resp", 32'(rc), 32'd2);
    chk("after_late_rdata", rd, 32'h0BAD_F00D);

    // clear alone
    step();
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    chk("clr_err",     32'(err_o), 32'd0);
    chk("clr_err_cnt", 32'(err_cnt_o), 32'd2);

    // clear coinciding with a timeout, then saturation
    run_txn(32'h4000_0000, 32'h0, 4'h0, 0, 32'h0, 16, rc, rd, ic, in_, hs, us);
    chk("clr_vs_set_err", 32'(err_o), 32'd1);
    chk("clr_vs_set_cnt", 32'(err_cnt_o), 32'd3);
    for (int i = 1; i < 300; i++)
      run_txn(32'h4000_0000 + 32'(i), 32'h0, 4'h0, 0, 32'h0, 0, rc, rd, ic, in_, hs, us);
    chk("sat_err_cnt",  32'(err_cnt_o), 32'd255);
    chk("sat_err_addr", err_addr_o, 32'h4000_0000 + 32'd299);
    step();
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    chk("sat_clr_err", 32'(err_o), 32'd0);
    chk("sat_clr_cnt", 32'(err_cnt_o), 32'd255);

    // reset during REQ
    step();
    slv_valid_i = 1'b1; slv_addr_i = 32'h6000_0000; slv_wstrb_i = 4'hF;
    step();
    chk("rq_mst_valid", 32'(mst_valid_o), 32'd1);
    repeat (3) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; slv_valid_i = 1'b0;
    chk("rq_rst_mst_valid", 32'(mst_valid_o), 32'd0);
    chk("rq_rst_slv_ready", 32'(slv_ready_o), 32'd0);
    chk("rq_rst_err",       32'(err_o), 32'd0);
    chk("rq_rst_err_cnt",   32'(err_cnt_o), 32'd0);
    chk("rq_rst_err_addr",  err_addr_o, 32'd0);
    chk("rq_rst_err_we",    32'(err_we_o), 32'd0);
    chk("rq_rst_rdata",     slv_rdata_o, 32'd0);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (slv_ready_o || irq_o || mst_valid_o) stray++;
    end
    chk("rq_no_stray_activity", 32'(stray), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
